// File: rtl/dac_spike_event_detect.sv
// Threshold-crossing spike detector for one DAC channel: TTL pulse with refractory
// hold-off, saturating event counter and a first-word-fall-through timestamp FIFO.
module dac_spike_event_detect #(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                dataclk,
    input  logic                reset,
    input  logic [31:0]         main_state,
    input  logic [5:0]          channel,
    input  logic [15:0]         DAC_register,
    input  logic [15:0]         DAC_thrsh,
    input  logic                DAC_thrsh_pol,
    input  logic                det_en,
    input  logic [7:0]          pulse_width,
    input  logic [7:0]          refractory,
    input  logic [TS_WIDTH-1:0] timestamp,
    input  logic                evt_rd_en,
    input  logic                ovf_clear,
    output logic                spike_ttl,
    output logic                evt_valid,
    output logic [TS_WIDTH-1:0] evt_data,
    output logic [15:0]         evt_count,
    output logic                evt_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] MS_CLK27_B = 32'd205;

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_PULSE   = 2'd1;
    localparam logic [1:0] ST_REFRACT = 2'd2;

    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL  = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic                is_b_s;
    logic                is_b_prev_r;
    logic                strobe_s;
    logic                hit_s;
    logic                hit_prev_r;
    logic                crossing_s;
    logic                accept_s;
    logic [1:0]          state_r;
    logic [7:0]          cnt_r;
    logic                spike_ttl_r;

    logic [TS_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         fill_r;
    logic                evt_valid_r;
    logic [TS_WIDTH-1:0] evt_data_r;
    logic [15:0]         evt_count_r;
    logic                evt_overflow_r;

    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic [AW:0]         fill_next_s;
    logic [AW-1:0]       rd_next_s;
    logic [TS_WIDTH-1:0] head_next_s;

    // Sample strobe: first cycle of ms_clk27_b on channel 0
    always_comb begin
        is_b_s     = (main_state == MS_CLK27_B);
        strobe_s   = is_b_s && !is_b_prev_r && (channel == 6'd0);
        hit_s      = DAC_thrsh_pol ? (DAC_register >= DAC_thrsh) : (DAC_register <= DAC_thrsh);
        crossing_s = hit_s && !hit_prev_r;
        accept_s   = strobe_s && crossing_s && det_en && (state_r == ST_ARMED);
    end

    // Edge-detect register and previous-hit history (kept on every strobe)
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            is_b_prev_r <= 1'b0;
            hit_prev_r  <= 1'b0;
        end else begin
            is_b_prev_r <= is_b_s;
            if (strobe_s) begin
                hit_prev_r <= hit_s;
            end
        end
    end

    // Pulse / refractory state machine; det_en low aborts from any state
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_ARMED;
            cnt_r       <= 8'd0;
            spike_ttl_r <= 1'b0;
        end else if (!det_en) begin
            state_r     <= ST_ARMED;
            cnt_r       <= 8'd0;
            spike_ttl_r <= 1'b0;
        end else if (strobe_s) begin
            case (state_r)
                ST_ARMED: begin
                    if (crossing_s) begin
                        state_r     <= ST_PULSE;
                        cnt_r       <= (pulse_width == 8'd0) ? 8'd1 : pulse_width;
                        spike_ttl_r <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r <= 8'd1) begin
                        spike_ttl_r <= 1'b0;
                        if (refractory == 8'd0) begin
                            state_r <= ST_ARMED;
                            cnt_r   <= 8'd0;
                        end else begin
                            state_r <= ST_REFRACT;
                            cnt_r   <= refractory;
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_REFRACT: begin
                    if (cnt_r <= 8'd1) begin
                        state_r <= ST_ARMED;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r     <= ST_ARMED;
                    cnt_r       <= 8'd0;
                    spike_ttl_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO next-state; the head is precomputed so evt_data can stay registered
    always_comb begin
        full_s      = (fill_r == CNT_FULL);
        pop_s       = evt_rd_en && evt_valid_r;
        push_s      = accept_s && (!full_s || pop_s);
        drop_s      = accept_s && full_s && !pop_s;
        rd_next_s   = rd_ptr_r;
        fill_next_s = fill_r;
        head_next_s = {TS_WIDTH{1'b0}};
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + CNT_ONE;
            2'b01:   fill_next_s = fill_r - CNT_ONE;
            default: fill_next_s = fill_r;
        endcase
        // A push landing on the new head slot bypasses the memory
        if (fill_next_s == {(AW+1){1'b0}}) begin
            head_next_s = {TS_WIDTH{1'b0}};
        end else if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = timestamp;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage
    always_ff @(posedge dataclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= timestamp;
        end
    end

    // FIFO pointers, registered head and status
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            fill_r      <= {(AW+1){1'b0}};
            evt_valid_r <= 1'b0;
            evt_data_r  <= {TS_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r    <= rd_next_s;
            fill_r      <= fill_next_s;
            evt_valid_r <= (fill_next_s != {(AW+1){1'b0}});
            evt_data_r  <= head_next_s;
        end
    end

    // Saturating event counter and sticky overflow (a drop beats a clear)
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            evt_count_r    <= 16'd0;
            evt_overflow_r <= 1'b0;
        end else begin
            if (accept_s && (evt_count_r != 16'hFFFF)) begin
                evt_count_r <= evt_count_r + 16'd1;
            end
            if (drop_s) begin
                evt_overflow_r <= 1'b1;
            end else if (ovf_clear) begin
                evt_overflow_r <= 1'b0;
            end
        end
    end

    assign spike_ttl    = spike_ttl_r;
    assign evt_valid    = evt_valid_r;
    assign evt_data     = evt_data_r;
    assign evt_count    = evt_count_r;
    assign evt_overflow = evt_overflow_r;

endmodule
